// File: rtl/summer_pkg.sv
// Shared constants, clog2 helper and stage payload type for the pipelined adder tree.
package summer_pkg;

  localparam int N_IN_DEF     = 33;
  localparam int IN_W_DEF     = 16;
  localparam int ACC_XTRA_DEF = 8;

  // Tree results are carried sign-extended into a fixed-width container.
  localparam int STAGE_DATA_W = 64;

  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/summer_level.sv
// One registered pairwise-add level of the adder tree; each output grows one bit.
module summer_level
  import summer_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int IN_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [N_IN*IN_W-1:0]           d,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [N_IN/2*(IN_W+1)-1:0]     q
);

  localparam int N_OUT = N_IN / 2;
  localparam int OUT_W = IN_W + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      q         <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      for (int i = 0; i < N_OUT; i++) begin
        q[i*OUT_W +: OUT_W] <= OUT_W'(signed'(d[2*i*IN_W +: IN_W]))
                             + OUT_W'(signed'(d[(2*i+1)*IN_W +: IN_W]));
      end
    end
  end

endmodule

// File: rtl/pipelined_summer.sv
// Multi-beat pipelined adder tree with accumulator and output hold/backpressure.
// Define PIPELINED_SUMMER_SAT_EN to saturate the accumulator and report sat.
module pipelined_summer
  import summer_pkg::*;
#(
  parameter  int N_IN     = N_IN_DEF,
  parameter  int IN_W     = IN_W_DEF,
  parameter  int ACC_XTRA = ACC_XTRA_DEF,
  localparam int LVL      = clog2(N_IN),
  localparam int TREE_W   = IN_W + LVL,
  localparam int ACC_W    = TREE_W + ACC_XTRA
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_IN-1:0][IN_W-1:0]   s_in,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic signed [ACC_W-1:0]     s_sum,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sat
);

  localparam int N_PAD = 1 << LVL;

  logic                     stall;
  logic [N_PAD*IN_W-1:0]    padded;
  stage_t                   tail;

  always_comb begin
    padded                 = '0;
    padded[N_IN*IN_W-1:0]  = s_in;
  end

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int CNT = N_PAD >> k;
    localparam int W   = IN_W + k;
    logic [CNT*W-1:0]         d;
    logic                     v;
    logic                     l;
    logic [CNT/2*(W+1)-1:0]   q;
    logic                     qv;
    logic                     ql;

    if (k == 0) begin : g_src
      assign d = padded;
      assign v = in_valid;
      assign l = in_last;
    end else begin : g_chain
      assign d = g_lvl[k-1].q;
      assign v = g_lvl[k-1].qv;
      assign l = g_lvl[k-1].ql;
    end

    summer_level #(.N_IN(CNT), .IN_W(W)) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (!stall),
      .in_valid  (v),
      .in_last   (l),
      .d         (d),
      .out_valid (qv),
      .out_last  (ql),
      .q         (q)
    );
  end

  always_comb begin
    tail.valid = g_lvl[LVL-1].qv;
    tail.last  = g_lvl[LVL-1].ql;
    tail.data  = STAGE_DATA_W'(signed'(g_lvl[LVL-1].q));
  end

  // Only a finished sum that cannot be handed over blocks the pipe.
  assign stall    = out_valid && !out_ready && tail.valid && tail.last;
  assign in_ready = !stall;

  logic                    first;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] acc_nxt;

`ifdef PIPELINED_SUMMER_SAT_EN
  logic signed [ACC_W:0]   wide;
  logic                    ovf;
  logic                    sat_sticky;
  logic                    sat_nxt;

  always_comb begin
    base    = first ? '0 : acc;
    ext     = ACC_W'(signed'(tail.data));
    wide    = (ACC_W+1)'(base) + (ACC_W+1)'(ext);
    ovf     = wide[ACC_W] != wide[ACC_W-1];
    acc_nxt = wide[ACC_W-1:0];
    if (ovf) acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    sat_nxt = (first ? 1'b0 : sat_sticky) | ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
      sat        <= 1'b0;
    end else if (!stall) begin
      if (tail.valid) begin
        sat_sticky <= sat_nxt;
        if (tail.last) sat <= sat_nxt;
        else if (out_valid && out_ready) sat <= 1'b0;
      end else if (out_valid && out_ready) begin
        sat <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    base    = first ? '0 : acc;
    ext     = ACC_W'(signed'(tail.data));
    acc_nxt = base + ext;
  end

  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      first     <= 1'b1;
      s_sum     <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (tail.valid) begin
        acc   <= acc_nxt;
        first <= tail.last;
      end
      if (tail.valid && tail.last) begin
        s_sum     <= acc_nxt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_summer.sv
// Directed bench for pipelined_summer: default instance plus an ACC_XTRA=0 instance for wrap/saturation.
module tb_pipelined_summer;

  localparam int N_IN   = 33;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 30;
  localparam int ACC_W0 = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_IN-1:0][IN_W-1:0] s_in = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, sat;
  logic signed [ACC_W-1:0] s_sum;

  logic [N_IN-1:0][IN_W-1:0] w_s_in = '0;
  logic w_in_valid = 1'b0, w_in_last = 1'b0, w_out_ready = 1'b1;
  logic w_in_ready, w_out_valid, w_sat;
  logic signed [ACC_W0-1:0] w_s_sum;

  pipelined_summer u_dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .s_sum(s_sum), .out_valid(out_valid), .out_ready(out_ready), .sat(sat)
  );

  pipelined_summer #(.ACC_XTRA(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .s_in(w_s_in), .in_valid(w_in_valid), .in_last(w_in_last),
    .in_ready(w_in_ready), .s_sum(w_s_sum), .out_valid(w_out_valid), .out_ready(w_out_ready), .sat(w_sat)
  );

  int n_checks = 0;
  int n_errors = 0;
  int out_cnt = 0;
  int w_out_cnt = 0;
  logic signed [63:0] exp_q[$];
  logic signed [63:0] held;
  logic held_ok = 1'b0;
  logic saw_stall = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sum_order", s_sum, exp_q.pop_front());
      check("sat_clear", sat, 0);
      out_cnt++;
    end
    if (rst_n && out_valid && !out_ready) begin
      if (held_ok) check("frozen", s_sum, held);
      held    = s_sum;
      held_ok = 1'b1;
      if (!in_ready) saw_stall = 1'b1;
    end else begin
      held_ok = 1'b0;
    end
    if (rst_n && w_out_valid) w_out_cnt++;
  end

  task automatic send(input int val, input logic last, output int waits);
    for (int i = 0; i < N_IN; i++) s_in[i] = IN_W'(val);
    in_valid = 1'b1;
    in_last  = last;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, c0, n;
    int vals[8] = '{5, -3, 0, 1000, -1, 32767, -32768, 12};

    #23;
    check("rst_out_valid", out_valid, 0);
    check("rst_s_sum", s_sum, 0);
    check("rst_sat", sat, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_w_out_valid", w_out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single beat of +1: latency 7 edges including the accepting one
    out_ready = 1'b1;
    exp_q.push_back(33);
    send(1, 1'b1, w);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_c%0d", c), out_valid, c == 6);
    end
    wait_drain();

    // three-beat sum
    c0 = out_cnt;
    exp_q.push_back(2211);
    send(100, 1'b0, w);
    send(-40, 1'b0, w);
    send(7, 1'b1, w);
    wait_drain();
    check("multi_once", out_cnt - c0, 1);

    // back-to-back single-beat sums
    c0 = out_cnt;
    foreach (vals[k]) exp_q.push_back(33 * vals[k]);
    foreach (vals[k]) begin
      send(vals[k], 1'b1, w);
      check("b2b_ready", w, 0);
    end
    wait_drain();
    check("b2b_count", out_cnt - c0, 8);

    // backpressure while streaming
    c0 = out_cnt;
    for (int k = 1; k <= 12; k++) exp_q.push_back(33 * (k * -7));
    fork
      begin
        out_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int k = 1; k <= 12; k++) send(k * -7, 1'b1, w);
      end
    join
    check("stall_seen", saw_stall, 1);
    wait_drain();
    check("stall_count", out_cnt - c0, 12);

    // reset in the middle of a sum with an undelivered result pending
    out_ready = 1'b0;
    send(3, 1'b1, w);
    send(5, 1'b0, w);
    send(5, 1'b0, w);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sum", s_sum, 99);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_sum", s_sum, 0);
    check("async_rst_sat", sat, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(66);
    send(2, 1'b1, w);
    wait_drain();

    // 300 beats of full-negative lanes into a zero-headroom accumulator
    c0 = w_out_cnt;
    for (int i = 0; i < N_IN; i++) w_s_in[i] = 16'h8000;
    check("w_ready", w_in_ready, 1);
    for (int b = 1; b <= 300; b++) begin
      w_in_valid = 1'b1;
      w_in_last  = (b == 300);
      @(posedge clk);
      #1;
    end
    w_in_valid = 1'b0;
    w_in_last  = 1'b0;
    n = 0;
    while (!w_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w_out_valid", w_out_valid, 1);
`ifdef PIPELINED_SUMMER_SAT_EN
    check("w_sum", w_s_sum, -2097152);
    check("w_sat", w_sat, 1);
`else
    check("w_sum", w_s_sum, -1441792);
    check("w_sat", w_sat, 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("w_once", w_out_cnt - c0, 1);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
